muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 10 +
 rtl/muldiv_div_step.sv | 19 +
 rtl/muldiv_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and iteration count for the HI/LO unit
// Contents: op_e (MULT..MTLO), state_e (IDLE/MUL/DIV/FIX), DIV_ITERS
package muldiv_pkg;
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_e;
   localparam int DIV_ITERS = 32;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: pipeline <-> HI/LO unit handshake bundle
// master (pipeline): drives start/op/src_a/src_b/cancel, observes busy/done/hi/lo
// slave (muldiv_ctrl): the reverse
interface muldiv_if;
   logic        start, cancel, busy, done;
   logic [2:0]  op;
   logic [31:0] src_a, src_b, hi, lo;
   modport master (output start, op, src_a, src_b, cancel, input busy, done, hi, lo);
   modport slave  (input start, op, src_a, src_b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring shift-subtract division iteration on magnitudes
// Ports: rem_i/quo_i partial remainder and dividend/quotient shift register, div_i divisor,
//        rem_o/quo_o values after this iteration
module muldiv_div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] div_i,
   output logic [31:0] rem_o,
   output logic [31:0] quo_o
);
   logic [32:0] trial, diff;
   always_comb begin
      trial = {rem_i, quo_i[31]};
      diff  = trial - {1'b0, div_i};
      // a borrow out of the 33-bit subtract means the divisor did not fit: restore
      rem_o = diff[32] ? trial[31:0] : diff[31:0];
      quo_o = {quo_i[30:0], ~diff[32]};
   end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MIPS HI/LO unit with 2-cycle MULT/MULTU, 33-cycle DIV/DIVU and 1-cycle MTHI/MTLO
// Ports: clk, resetn (async active-low),
//        bus (muldiv_if.slave: start/op/src_a/src_b/cancel in, busy/done/hi/lo out)
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic    clk,
   input  logic    resetn,
   muldiv_if.slave bus
);
   state_e      state;
   logic [4:0]  cnt;
   logic        busy_r, done_r, sgn, qneg, rneg, bz;
   logic        is_mul, is_div, sdiv;
   logic [31:0] hi_r, lo_r, qa, qb, rem, nq, nr, abs_a, abs_b;
   logic [63:0] ma, mb, prod;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
   always_comb begin
      is_mul = bus.op == OP_MULT || bus.op == OP_MULTU;
      is_div = bus.op == OP_DIV || bus.op == OP_DIVU;
      sdiv   = bus.op == OP_DIV;
      abs_a  = sdiv && bus.src_a[31] ? -bus.src_a : bus.src_a;
      abs_b  = sdiv && bus.src_b[31] ? -bus.src_b : bus.src_b;
      // sign-extend to 64 bits for MULT so the modulo-2^64 product is the signed result
      ma     = {{32{sgn & qa[31]}}, qa};
      mb     = {{32{sgn & qb[31]}}, qb};
      prod   = ma * mb;
   end
   // qa doubles as multiplicand and as the dividend/quotient shift register
   muldiv_div_step u_step (.rem_i(rem), .quo_i(qa), .div_i(qb), .rem_o(nr), .quo_o(nq));
   // done rises at the commit edge, so it is seen together with the new hi/lo
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state  <= S_IDLE;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         qa     <= '0;
         qb     <= '0;
         rem    <= '0;
         sgn    <= 1'b0;
         qneg   <= 1'b0;
         rneg   <= 1'b0;
         bz     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state != S_IDLE && bus.cancel) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
         end else
            case (state)
               S_IDLE: if (bus.start && !bus.cancel) begin
                  qa     <= is_mul ? bus.src_a : abs_a;
                  qb     <= is_mul ? bus.src_b : abs_b;
                  rem    <= '0;
                  cnt    <= '0;
                  sgn    <= bus.op == OP_MULT;
                  qneg   <= sdiv & (bus.src_a[31] ^ bus.src_b[31]);
                  rneg   <= sdiv & bus.src_a[31];
                  bz     <= bus.src_b == '0;
                  hi_r   <= bus.op == OP_MTHI ? bus.src_a : hi_r;
                  lo_r   <= bus.op == OP_MTLO ? bus.src_a : lo_r;
                  state  <= is_mul ? S_MUL : is_div ? S_DIV : S_IDLE;
                  busy_r <= is_mul | is_div;
               end
               S_MUL: begin
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd1) begin
                     {hi_r, lo_r} <= prod;
                     done_r       <= 1'b1;
                     state        <= S_IDLE;
                     busy_r       <= 1'b0;
                     cnt          <= '0;
                  end
               end
               S_DIV: begin
                  qa  <= nq;
                  rem <= nr;
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'(DIV_ITERS - 1)) begin
                     state <= S_FIX;
                     cnt   <= '0;
                  end
               end
               S_FIX: begin
                  // divide-by-zero leaves rem = |a|, so only the quotient needs forcing
                  lo_r   <= bz ? '1 : qneg ? -qa : qa;
                  hi_r   <= rneg ? -rem : rem;
                  done_r <= 1'b1;
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end
            endcase
      end
endmodule
